axi_stream_header_arbiter: RTL and testbench
============================================

// Module: axi_stream_header_arbiter
// PURPOSE
//  Shares the header-insert port of axi_stream_insert_header between NUM_REQ header sources.
//  Grants one source per packet, round-robin, and latches its header.
//  Presents the header on valid_insert/data_insert/keep_insert/byte_insert_cnt.
//  Holds the grant until the inserter's output completes the packet (last_out handshake).
// PARAMETERS
//  NUM_REQ       4                      number of header requesters (>=2)
//  DATA_WD       32                     header/data width, bits
//  DATA_BYTE_WD  DATA_WD/8              keep width
//  BYTE_CNT_WD   $clog2(DATA_BYTE_WD)   byte_insert_cnt width
//  ID_WD         $clog2(NUM_REQ)        grant index width
// PORTS
//  clk              in   1                     clock, rising edge
//  rst_n            in   1                     asynchronous active-low reset
//  req_valid        in   NUM_REQ               per-source header valid
//  req_data         in   NUM_REQ*DATA_WD       source i in bits [i*DATA_WD +: DATA_WD]
//  req_keep         in   NUM_REQ*DATA_BYTE_WD  per-source header keep
//  req_byte_cnt     in   NUM_REQ*BYTE_CNT_WD   per-source byte_insert_cnt
//  req_ready        out  NUM_REQ               one-hot; pulses 1 cycle on capture
//  valid_insert     out  1                     to inserter
//  data_insert      out  DATA_WD               to inserter
//  keep_insert      out  DATA_BYTE_WD          to inserter
//  byte_insert_cnt  out  BYTE_CNT_WD           to inserter
//  ready_insert     in   1                     from inserter
//  mon_valid_out    in   1                     tap of inserter valid_out
//  mon_ready_out    in   1                     tap of inserter ready_out
//  mon_last_out     in   1                     tap of inserter last_out
//  grant_id         out  ID_WD                 index of current/last granted source
//  grant_active     out  1                     high in OFFER and WAIT_EOP
//  pkt_cnt          out  16                    completed packets; wraps 0xFFFF->0
//  err_early_eop    out  1                     sticky; EOP seen outside WAIT_EOP
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, grant_id=0, pkt_cnt=0, err_early_eop=0; all other outputs 0.
//  Reset mid-packet abandons the grant; no header is replayed.
//  State IDLE:
//   - If |req_valid: g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[g]=1 (combinational, same cycle). Latch data/keep/byte_cnt of g; grant_id<=g; ->OFFER.
//   - req_ready is 0 in every other state.
//  State OFFER:
//   - valid_insert=1; outputs are the latched regs, stable until the handshake.
//   - valid_insert&ready_insert -> WAIT_EOP; valid_insert deasserts the next cycle.
//   - Latency: req_valid high at edge N -> valid_insert high at edge N+1.
//  State WAIT_EOP:
//   - eop = mon_valid_out & mon_ready_out & mon_last_out.
//   - On eop: ->IDLE, rr_ptr <= (grant_id+1) mod NUM_REQ (NUM_REQ need not be 2^n), pkt_cnt+1.
//  Boundary behaviour:
//   - eop in IDLE or OFFER sets err_early_eop (cleared only by reset); state unaffected.
//   - eop while ready_insert handshakes in OFFER: header is accepted, eop is flagged as error.
//   - Minimum gap: eop cycle -> IDLE; next grant capture 1 cycle later.
//   - A source dropping req_valid before capture is skipped silently.
//   - Inputs of non-granted sources are ignored.
// STRUCTURE
//  Shared package axi_stream_insert_pkg:
//   - state encoding IDLE=2'd0, OFFER=2'd1, WAIT_EOP=2'd2
//   - PKT_CNT_WD=16
//  Sub-module axi_stream_rr_arbiter (NUM_REQ): combinational; req vector + rr_ptr -> one-hot grant + index + any.
//  Top holds the FSM, header latch, rr_ptr, counters.
// TESTING
//  1 Single source: req_valid=4'b0001, hdr 0xA1B2C3D4, keep 4'b0011, cnt 1.
//    -> req_ready[0] 1-cycle pulse; valid_insert next cycle with those values.
//    -> last_out handshake -> pkt_cnt=1, rr_ptr=1.
//  2 All four valid continuously, 8 packets -> grant_id order 0,1,2,3,0,1,2,3; pkt_cnt=8.
//  3 ready_insert held low 5 cycles in OFFER -> valid_insert and data_insert stable all 5; no req_ready pulses.
//  4 NUM_REQ=3, grant 2 completes -> rr_ptr=0; with req_valid=3'b110 next grant_id=1.
//  5 last_out handshake injected in IDLE -> err_early_eop=1 and stays; the next packet completes normally.
//  6 rst_n low mid WAIT_EOP -> all outputs 0 immediately; after release rr_ptr=0, pkt_cnt=0.
//    -> pkt_cnt=0xFFFF then one more eop -> 0.

Source files
------------

// File: rtl/axi_stream_insert_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_insert_pkg
// Description : Shared definitions for the header-insert path. Holds the
//               arbiter state encoding and the packet counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_insert_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OFFER    = 2'd1;
    localparam logic [1:0] ST_WAIT_EOP = 2'd2;

    // Completed-packet counter width
    localparam int PKT_CNT_WD = 16;

endpackage : axi_stream_insert_pkg
`default_nettype wire

// File: rtl/axi_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_rr_arbiter
// Description : Purely combinational round-robin pick. Searches req starting
//               at rr_ptr and wrapping modulo NUM_REQ (NUM_REQ need not be a
//               power of two).
// Ports       : req        - request vector
//               rr_ptr     - highest-priority index (must be < NUM_REQ)
//               grant      - one-hot grant, all zero when no request
//               grant_idx  - index of the granted request
//               any_valid  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WD   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_WD-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_WD-1:0]   grant_idx,
    output logic               any_valid
);

    int             pos;
    logic [ID_WD-1:0] pos_idx;

    always_comb begin
        grant_idx = '0;
        pos       = 0;
        pos_idx   = '0;
        any_valid = |req;
        // Walk from the farthest offset back to rr_ptr so that the request
        // closest to rr_ptr (in wrap order) is the one that sticks.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = ID_WD'(pos);
            if (req[pos_idx]) begin
                grant_idx = pos_idx;
            end
        end
        grant = any_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule : axi_stream_rr_arbiter
`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_header_arbiter
// Description : Shares the header-insert port of the stream inserter among
//               NUM_REQ header sources. One source is granted per packet in
//               round-robin order; its header is latched and offered to the
//               inserter, and the grant is held until the inserter's output
//               completes the packet (last_out handshake).
// Ports       : req_*            - per-source header (valid/data/keep/cnt)
//               req_ready        - one-hot, pulses in the capture cycle
//               *_insert         - header towards the inserter
//               mon_*_out        - taps of the inserter's output handshake
//               grant_id         - current / last granted source
//               grant_active     - high while a grant is outstanding
//               pkt_cnt          - completed packets, wrapping
//               err_early_eop    - sticky, EOP seen with no packet in flight
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_header_arbiter
    import axi_stream_insert_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int ID_WD        = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            mon_valid_out,
    input  logic                            mon_ready_out,
    input  logic                            mon_last_out,
    output logic [ID_WD-1:0]                grant_id,
    output logic                            grant_active,
    output logic [PKT_CNT_WD-1:0]           pkt_cnt,
    output logic                            err_early_eop
);

    // ------------------------------------------------------------------
    // Per-source views of the packed request buses
    // ------------------------------------------------------------------
    logic [DATA_WD-1:0]      src_data [NUM_REQ];
    logic [DATA_BYTE_WD-1:0] src_keep [NUM_REQ];
    logic [BYTE_CNT_WD-1:0]  src_cnt  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign src_data[i] = req_data[i*DATA_WD +: DATA_WD];
        assign src_keep[i] = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        assign src_cnt[i]  = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]              state_q,    state_d;
    logic [ID_WD-1:0]        rr_ptr_q,   rr_ptr_d;
    logic [ID_WD-1:0]        grant_id_q, grant_id_d;
    logic [DATA_WD-1:0]      data_q,     data_d;
    logic [DATA_BYTE_WD-1:0] keep_q,     keep_d;
    logic [BYTE_CNT_WD-1:0]  cnt_q,      cnt_d;
    logic [PKT_CNT_WD-1:0]   pkt_cnt_q,  pkt_cnt_d;
    logic                    err_q,      err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_WD-1:0]   arb_idx;
    logic               arb_any;
    logic               eop;
    logic               hdr_hs;

    axi_stream_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WD   (ID_WD)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    assign eop    = mon_valid_out & mon_ready_out & mon_last_out;
    assign hdr_hs = (state_q == ST_OFFER) & ready_insert;

    // ------------------------------------------------------------------
    // FSM: state register (with datapath flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            cnt_q      <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            cnt_q      <= cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (arb_any) state_d = ST_OFFER;
            ST_OFFER:    if (hdr_hs)  state_d = ST_WAIT_EOP;
            ST_WAIT_EOP: if (eop)     state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready    = '0;
        valid_insert = 1'b0;
        grant_active = 1'b0;
        case (state_q)
            ST_IDLE:     req_ready = arb_grant;
            ST_OFFER:    begin valid_insert = 1'b1; grant_active = 1'b1; end
            ST_WAIT_EOP: grant_active = 1'b1;
            default:     ;
        endcase
    end

    // ------------------------------------------------------------------
    // Header latch, round-robin pointer and counters
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        data_d     = data_q;
        keep_d     = keep_q;
        cnt_d      = cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_d      = err_q;

        if ((state_q == ST_IDLE) && arb_any) begin
            grant_id_d = arb_idx;
            data_d     = src_data[arb_idx];
            keep_d     = src_keep[arb_idx];
            cnt_d      = src_cnt[arb_idx];
        end

        if (eop) begin
            if (state_q == ST_WAIT_EOP) begin
                pkt_cnt_d = pkt_cnt_q + PKT_CNT_WD'(1);
                // Explicit wrap: NUM_REQ may not fill the index width
                rr_ptr_d  = (grant_id_q == ID_WD'(NUM_REQ - 1)) ? '0
                                                               : grant_id_q + ID_WD'(1);
            end else begin
                // EOP with no packet in flight; also covers the cycle where
                // the header handshake coincides with an EOP in OFFER.
                err_d = 1'b1;
            end
        end
    end

    assign data_insert     = data_q;
    assign keep_insert     = keep_q;
    assign byte_insert_cnt = cnt_q;
    assign grant_id        = grant_id_q;
    assign pkt_cnt         = pkt_cnt_q;
    assign err_early_eop   = err_q;

endmodule : axi_stream_header_arbiter
`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_header_arbiter
// Description : Directed bench. Expected headers are queued when a grant is
//               provoked; a monitor pops and compares on every header
//               handshake. A second 3-source instance covers the non-power-
//               of-two pointer wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-source instance
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [15:0]  req_keep;
    logic [7:0]   req_byte_cnt;
    logic [3:0]   req_ready;
    logic         valid_insert;
    logic [31:0]  data_insert;
    logic [3:0]   keep_insert;
    logic [1:0]   byte_insert_cnt;
    logic         ready_insert;
    logic         mon_v, mon_r, mon_l;
    logic [1:0]   grant_id;
    logic         grant_active;
    logic [15:0]  pkt_cnt;
    logic         err_early_eop;

    axi_stream_header_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
        .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
        .valid_insert(valid_insert), .data_insert(data_insert),
        .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
        .ready_insert(ready_insert),
        .mon_valid_out(mon_v), .mon_ready_out(mon_r), .mon_last_out(mon_l),
        .grant_id(grant_id), .grant_active(grant_active),
        .pkt_cnt(pkt_cnt), .err_early_eop(err_early_eop)
    );

    // 3-source instance
    logic [2:0]  r3_valid;
    logic [95:0] r3_data;
    logic [11:0] r3_keep;
    logic [5:0]  r3_cnt;
    logic [2:0]  r3_ready;
    logic        v3_ins, ready3, m3;
    logic [31:0] d3_ins;
    logic [3:0]  k3_ins;
    logic [1:0]  c3_ins, g3_id;
    logic        g3_act, e3;
    logic [15:0] p3_cnt;

    axi_stream_header_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r3_valid), .req_data(r3_data), .req_keep(r3_keep),
        .req_byte_cnt(r3_cnt), .req_ready(r3_ready),
        .valid_insert(v3_ins), .data_insert(d3_ins),
        .keep_insert(k3_ins), .byte_insert_cnt(c3_ins),
        .ready_insert(ready3),
        .mon_valid_out(m3), .mon_ready_out(m3), .mon_last_out(m3),
        .grant_id(g3_id), .grant_active(g3_act),
        .pkt_cnt(p3_cnt), .err_early_eop(e3)
    );

    // Per-source header table
    logic [31:0] hdr_tab  [4] = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [3:0]  keep_tab [4] = '{4'b0011, 4'b1111, 4'b0111, 4'b0001};
    logic [1:0]  cnt_tab  [4] = '{2'd1, 2'd3, 2'd2, 2'd0};

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_pkt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples 1 ns before each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && valid_insert && ready_insert) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL hdr_unexpected: got header %0h, expected none", data_insert);
                end else begin
                    e = exp_q.pop_front();
                    chk("hdr_data", data_insert, e.data);
                    chk("hdr_keep", keep_insert, e.keep);
                    chk("hdr_cnt",  byte_insert_cnt, e.cnt);
                    chk("hdr_id",   grant_id, e.id);
                end
            end
        end
    end

    // One packet on the 4-source instance; called and returning near a
    // falling edge. hold = cycles ready_insert stays low in OFFER; abort
    // leaves the DUT in WAIT_EOP.
    task automatic run_pkt(input logic [3:0] vmask, input int exp_id,
                           input int hold, input bit abort);
        exp_t e;
        e.id   = 2'(exp_id);
        e.data = hdr_tab[exp_id];
        e.keep = keep_tab[exp_id];
        e.cnt  = cnt_tab[exp_id];
        req_valid = vmask;
        exp_q.push_back(e);
        #1 chk("req_ready_pulse", req_ready, 64'(4'b0001 << exp_id));
        @(negedge clk);
        chk("offer_valid", valid_insert, 1);
        chk("offer_no_ready", req_ready, 0);
        chk("offer_grant_id", grant_id, exp_id);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", valid_insert, 1);
            chk("hold_data", data_insert, hdr_tab[exp_id]);
            chk("hold_no_ready", req_ready, 0);
            @(negedge clk);
        end
        ready_insert = 1'b1;
        @(negedge clk);
        ready_insert = 1'b0;
        #1 chk("valid_drop", valid_insert, 0);
        chk("wait_active", grant_active, 1);
        if (abort) begin
            req_valid = '0;
            return;
        end
        {mon_v, mon_r, mon_l} = 3'b111;
        @(negedge clk);
        {mon_v, mon_r, mon_l} = 3'b000;
        req_valid = '0;
        exp_pkt   = exp_pkt + 16'd1;
        #1 chk("pkt_cnt", pkt_cnt, exp_pkt);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        exp_pkt = '0;
        #1;
        chk("rst_valid", valid_insert, 0);
        chk("rst_active", grant_active, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err", err_early_eop, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_data", data_insert, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0; ready_insert = 1'b0; {mon_v, mon_r, mon_l} = 3'b000;
        r3_valid = '0; ready3 = 1'b0; m3 = 1'b0;
        r3_keep = '1; r3_cnt = '0;
        r3_data = {32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32]   = hdr_tab[i];
            req_keep[i*4 +: 4]     = keep_tab[i];
            req_byte_cnt[i*2 +: 2] = cnt_tab[i];
        end
        @(negedge clk);
        do_reset();

        // 1: single source 0
        run_pkt(4'b0001, 0, 0, 0);
        // rr_ptr now 1: all valid must pick source 1
        run_pkt(4'b1111, 1, 0, 0);

        // 2: all four valid, 8 packets from a fresh pointer
        do_reset();
        for (int k = 0; k < 8; k++) run_pkt(4'b1111, k % 4, 0, 0);
        chk("pkt_cnt_8", pkt_cnt, 8);

        // 3: ready_insert held low 5 cycles in OFFER
        run_pkt(4'b0100, 2, 5, 0);

        // 4: 3-source wrap: grant 2 completes, then 3'b110 picks 1
        r3_valid = 3'b100;
        #1 chk("r3_ready_2", r3_ready, 3'b100);
        @(negedge clk);
        chk("r3_grant_2", g3_id, 2);
        r3_valid = '0; ready3 = 1'b1;
        @(negedge clk);
        ready3 = 1'b0; m3 = 1'b1;
        @(negedge clk);
        m3 = 1'b0;
        chk("r3_pkt_cnt", p3_cnt, 1);
        r3_valid = 3'b110;
        #1 chk("r3_ready_1", r3_ready, 3'b010);
        @(negedge clk);
        chk("r3_grant_1", g3_id, 1);
        r3_valid = '0;

        // 5: early EOP in IDLE
        {mon_v, mon_r, mon_l} = 3'b111;
        @(negedge clk);
        {mon_v, mon_r, mon_l} = 3'b000;
        #1 chk("err_set", err_early_eop, 1);
        chk("err_no_count", pkt_cnt, exp_pkt);
        @(negedge clk);
        run_pkt(4'b1000, 3, 0, 0);
        chk("err_sticky", err_early_eop, 1);

        // 6: reset in WAIT_EOP, then counter wrap
        run_pkt(4'b0010, 1, 0, 1);
        do_reset();
        force u_dut.pkt_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.pkt_cnt_q;
        exp_pkt = 16'hFFFF;
        @(negedge clk);
        chk("pkt_cnt_max", pkt_cnt, 16'hFFFF);
        run_pkt(4'b1111, 0, 0, 0);
        chk("pkt_cnt_wrap", pkt_cnt, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_axi_stream_header_arbiter
`default_nettype wire
